// File: rtl/eac_cla_adder_pipe_pkg.sv
// Shared defaults and configuration checks for the pipelined EAC carry-select adder.
// Defaults match the BF16 FMA mantissa datapath.
package eac_cla_adder_pipe_pkg;

    localparam int unsigned ADDER_WIDTH_DEF   = 24;
    localparam int unsigned CLA_GRP_WIDTH_DEF = 12;
    localparam int unsigned N_CLA_GROUPS_DEF  = ADDER_WIDTH_DEF / CLA_GRP_WIDTH_DEF;
    localparam int unsigned TAG_WIDTH_DEF     = 8;

    // Per-beat mode bits that travel with the group sums through stage 1.
    typedef struct packed {
        logic eac;
        logic cin;
        logic pos_zero_en;
    } eac_ctrl_t;

    function automatic bit cla_cfg_legal(input int unsigned w, input int unsigned g);
        return (g != 0) && ((w % g) == 0) && ((w / g) >= 2);
    endfunction

endpackage

// File: rtl/eac_cla_adder_pipe_if.sv
// Valid/ready beat interface for the EAC adder: operand/mode/tag in, sum/flags/tag out.
interface eac_cla_adder_pipe_if
    import eac_cla_adder_pipe_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int unsigned TAG_WIDTH   = TAG_WIDTH_DEF
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDER_WIDTH-1:0] in1;
    logic [ADDER_WIDTH-1:0] in2;
    logic                   cin;
    logic                   sticky;
    logic                   eff_op;
    logic                   pos_zero_en;
    logic [TAG_WIDTH-1:0]   tag_in;

    logic                   out_valid;
    logic                   out_ready;
    logic [ADDER_WIDTH-1:0] sum;
    logic                   cout;
    logic                   zero;
    logic [TAG_WIDTH-1:0]   tag_out;

    modport master (
        output in_valid, in1, in2, cin, sticky, eff_op, pos_zero_en, tag_in, out_ready,
        input  in_ready, out_valid, sum, cout, zero, tag_out
    );

    modport slave (
        input  in_valid, in1, in2, cin, sticky, eff_op, pos_zero_en, tag_in, out_ready,
        output in_ready, out_valid, sum, cout, zero, tag_out
    );

endinterface

// File: rtl/eac_cla_group_pg.sv
// One carry-select group: both candidate sums plus group generate/propagate.
module eac_cla_group_pg
    import eac_cla_adder_pipe_pkg::*;
#(
    parameter int unsigned GRP_WIDTH = CLA_GRP_WIDTH_DEF
) (
    input  logic [GRP_WIDTH-1:0] a,
    input  logic [GRP_WIDTH-1:0] b,
    output logic [GRP_WIDTH-1:0] sum_basic,
    output logic [GRP_WIDTH-1:0] sum_plus_one,
    output logic                 gg,
    output logic                 gp
);
    logic [GRP_WIDTH:0] raw;

    assign raw          = {1'b0, a} + {1'b0, b};
    assign sum_basic    = raw[GRP_WIDTH-1:0];
    assign sum_plus_one = sum_basic + GRP_WIDTH'(1);
    assign gg           = raw[GRP_WIDTH];
    // All bits propagate: a carry-in ripples straight through the group.
    assign gp           = &(a ^ b);

endmodule

// File: rtl/eac_cla_adder_pipe.sv
// Pipelined end-around-carry carry-select adder with valid/ready flow control.
// Groups precompute sum/sum+1; a rotated look-ahead picks the per-group carry-in.
module eac_cla_adder_pipe
    import eac_cla_adder_pipe_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH   = ADDER_WIDTH_DEF,
    parameter int unsigned CLA_GRP_WIDTH = CLA_GRP_WIDTH_DEF,
    parameter int unsigned PIPE_STAGES   = 2,
    parameter int unsigned TAG_WIDTH     = TAG_WIDTH_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    eac_cla_adder_pipe_if.slave bus
);
    localparam int unsigned W = ADDER_WIDTH;
    localparam int unsigned G = CLA_GRP_WIDTH;
    localparam int unsigned N = W / G;

    if (!cla_cfg_legal(W, G)) begin : g_bad_cfg
        $error("eac_cla_adder_pipe: ADDER_WIDTH must be a multiple of CLA_GRP_WIDTH, >= 2 groups");
    end
    if ((PIPE_STAGES != 1) && (PIPE_STAGES != 2)) begin : g_bad_stages
        $error("eac_cla_adder_pipe: PIPE_STAGES must be 1 or 2");
    end

    // ---------------------------------------------------------------- group front end
    logic [W-1:0] f_basic;
    logic [W-1:0] f_plus;
    logic [N-1:0] f_gg;
    logic [N-1:0] f_gp;
    eac_ctrl_t    f_ctrl;

    for (genvar k = 0; k < N; k++) begin : g_grp
        eac_cla_group_pg #(
            .GRP_WIDTH(G)
        ) u_grp (
            .a           (bus.in1[k*G +: G]),
            .b           (bus.in2[k*G +: G]),
            .sum_basic   (f_basic[k*G +: G]),
            .sum_plus_one(f_plus[k*G +: G]),
            .gg          (f_gg[k]),
            .gp          (f_gp[k])
        );
    end

    assign f_ctrl.eac         = bus.eff_op & ~bus.sticky;
    assign f_ctrl.cin         = bus.cin;
    assign f_ctrl.pos_zero_en = bus.pos_zero_en;

    // ---------------------------------------------------------------- stage 1 / bypass
    logic [W-1:0]         r_basic;
    logic [W-1:0]         r_plus;
    logic [N-1:0]         r_gg;
    logic [N-1:0]         r_gp;
    eac_ctrl_t            r_ctrl;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_valid;
    logic                 s1_ready;
    logic                 out_ld;

    if (PIPE_STAGES == 2) begin : g_two
        logic                 v1_q;
        logic [W-1:0]         basic_q;
        logic [W-1:0]         plus_q;
        logic [N-1:0]         gg_q;
        logic [N-1:0]         gp_q;
        eac_ctrl_t            ctrl_q;
        logic [TAG_WIDTH-1:0] tag_q;

        // Stage 1 advances whenever the output stage can take its contents.
        assign s1_ready = ~v1_q | out_ld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q    <= 1'b0;
                basic_q <= '0;
                plus_q  <= '0;
                gg_q    <= '0;
                gp_q    <= '0;
                ctrl_q  <= '0;
                tag_q   <= '0;
            end else begin
                if (s1_ready) begin
                    v1_q <= bus.in_valid;
                end
                if (s1_ready && bus.in_valid) begin
                    basic_q <= f_basic;
                    plus_q  <= f_plus;
                    gg_q    <= f_gg;
                    gp_q    <= f_gp;
                    ctrl_q  <= f_ctrl;
                    tag_q   <= bus.tag_in;
                end
            end
        end

        assign r_basic = basic_q;
        assign r_plus  = plus_q;
        assign r_gg    = gg_q;
        assign r_gp    = gp_q;
        assign r_ctrl  = ctrl_q;
        assign r_tag   = tag_q;
        assign r_valid = v1_q;
    end else begin : g_one
        assign s1_ready = out_ld;
        assign r_basic  = f_basic;
        assign r_plus   = f_plus;
        assign r_gg     = f_gg;
        assign r_gp     = f_gp;
        assign r_ctrl   = f_ctrl;
        assign r_tag    = bus.tag_in;
        assign r_valid  = bus.in_valid;
    end

    // ---------------------------------------------------------------- carry resolution
    logic [N:0]   c_lo;
    logic [N:0]   c;
    logic         g_all;
    logic         p_all;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_zero;

    always_comb begin
        c_lo     = '0;
        c        = '0;
        res_sum  = '0;
        res_cout = 1'b0;
        res_zero = 1'b0;

        for (int k = 0; k < int'(N); k++) begin
            c_lo[k+1] = r_gg[k] | (r_gp[k] & c_lo[k]);
        end
        g_all = c_lo[N];
        p_all = &r_gp;

        // Wrapping the whole-word generate into group 0 equals the rotated look-ahead:
        // when every group propagates no group generates, so the ring never self-feeds.
        c[0] = r_ctrl.eac ? g_all : r_ctrl.cin;
        for (int k = 0; k < int'(N); k++) begin
            c[k+1]           = r_gg[k] | (r_gp[k] & c[k]);
            res_sum[k*G +: G] = c[k] ? r_plus[k*G +: G] : r_basic[k*G +: G];
        end
        res_cout = c[N];

        // All-propagate in EAC mode is the -0 pattern.
        if (r_ctrl.eac && p_all && r_ctrl.pos_zero_en) begin
            res_sum  = '0;
            res_cout = 1'b1;
        end
        res_zero = (res_sum == '0);
    end

    // ---------------------------------------------------------------- output stage
    logic                 vo_q;
    logic [W-1:0]         sum_q;
    logic                 cout_q;
    logic                 zero_q;
    logic [TAG_WIDTH-1:0] tag_out_q;

    assign out_ld = ~vo_q | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo_q      <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            tag_out_q <= '0;
        end else begin
            if (out_ld) begin
                vo_q <= r_valid;
            end
            if (out_ld && r_valid) begin
                sum_q     <= res_sum;
                cout_q    <= res_cout;
                zero_q    <= res_zero;
                tag_out_q <= r_tag;
            end
        end
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = vo_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.tag_out   = tag_out_q;

endmodule

// File: tb/tb_eac_cla_adder_pipe.sv
// Directed self-checking bench: a 24/12/2-stage instance and a 32/8/1-stage instance.
module tb_eac_cla_adder_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sticky;
        logic        eff;
        logic        pz;
        logic [31:0] s;
        logic        co;
        logic        z;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    eac_cla_adder_pipe_if #(.ADDER_WIDTH(24), .TAG_WIDTH(8)) bus_a ();
    eac_cla_adder_pipe_if #(.ADDER_WIDTH(32), .TAG_WIDTH(8)) bus_b ();

    eac_cla_adder_pipe #(
        .ADDER_WIDTH  (24),
        .CLA_GRP_WIDTH(12),
        .PIPE_STAGES  (2),
        .TAG_WIDTH    (8)
    ) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    eac_cla_adder_pipe #(
        .ADDER_WIDTH  (32),
        .CLA_GRP_WIDTH(8),
        .PIPE_STAGES  (1),
        .TAG_WIDTH    (8)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_ov(input bit use_b);
        return use_b ? 64'(bus_b.out_valid) : 64'(bus_a.out_valid);
    endfunction
    function automatic logic [63:0] get_ir(input bit use_b);
        return use_b ? 64'(bus_b.in_ready) : 64'(bus_a.in_ready);
    endfunction
    function automatic logic [63:0] get_sum(input bit use_b);
        return use_b ? 64'(bus_b.sum) : 64'(bus_a.sum);
    endfunction
    function automatic logic [63:0] get_cout(input bit use_b);
        return use_b ? 64'(bus_b.cout) : 64'(bus_a.cout);
    endfunction
    function automatic logic [63:0] get_zero(input bit use_b);
        return use_b ? 64'(bus_b.zero) : 64'(bus_a.zero);
    endfunction
    function automatic logic [63:0] get_tag(input bit use_b);
        return use_b ? 64'(bus_b.tag_out) : 64'(bus_a.tag_out);
    endfunction

    task automatic drive(input bit use_b, input vec_t v, input logic [7:0] tag);
        if (use_b) begin
            bus_b.in1 = v.a;  bus_b.in2 = v.b;  bus_b.cin = v.cin;  bus_b.sticky = v.sticky;
            bus_b.eff_op = v.eff;  bus_b.pos_zero_en = v.pz;  bus_b.tag_in = tag;
            bus_b.in_valid = 1'b1;
        end else begin
            bus_a.in1 = v.a[23:0];  bus_a.in2 = v.b[23:0];  bus_a.cin = v.cin;
            bus_a.sticky = v.sticky;  bus_a.eff_op = v.eff;  bus_a.pos_zero_en = v.pz;
            bus_a.tag_in = tag;  bus_a.in_valid = 1'b1;
        end
    endtask

    task automatic idle(input bit use_b);
        if (use_b) bus_b.in_valid = 1'b0;
        else       bus_a.in_valid = 1'b0;
    endtask

    // One isolated beat with out_ready high: checks latency and the result fields.
    task automatic run_vec(input bit use_b, input vec_t v, input logic [7:0] tag,
                           input int lat_exp, input string name);
        int lat;
        drive(use_b, v, tag);
        #1;
        check_eq({name, "_in_ready"}, get_ir(use_b), 64'd1);
        @(posedge clk); #1;
        idle(use_b);
        lat = 1;
        while (get_ov(use_b) != 64'd1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({name, "_latency"}, 64'(lat), 64'(lat_exp));
        check_eq({name, "_sum"}, get_sum(use_b), 64'(v.s));
        check_eq({name, "_cout"}, get_cout(use_b), 64'(v.co));
        check_eq({name, "_zero"}, get_zero(use_b), 64'(v.z));
        check_eq({name, "_tag"}, get_tag(use_b), 64'(tag));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input bit use_b, input string name);
        check_eq({name, "_out_valid"}, get_ov(use_b), 64'd0);
        check_eq({name, "_in_ready"}, get_ir(use_b), 64'd1);
        check_eq({name, "_sum"}, get_sum(use_b), 64'd0);
        check_eq({name, "_cout"}, get_cout(use_b), 64'd0);
        check_eq({name, "_zero"}, get_zero(use_b), 64'd0);
        check_eq({name, "_tag"}, get_tag(use_b), 64'd0);
    endtask

    vec_t vecs_a[12];
    vec_t vecs_b[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got %0d expected run completion", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bp;
        int   nxt;
        int   got;

        //            a             b            cin   sticky eff   pz    sum           co    z
        vecs_a[0]  = '{32'h00FFFF, 32'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h010000, 1'b0, 1'b0};
        vecs_a[1]  = '{32'hFFFFFF, 32'h000002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h000002, 1'b1, 1'b0};
        vecs_a[2]  = '{32'hFFFFFF, 32'h000002, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000001, 1'b1, 1'b0};
        vecs_a[3]  = '{32'hAAAAAA, 32'h555555, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000, 1'b1, 1'b1};
        vecs_a[4]  = '{32'hAAAAAA, 32'h555555, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFF, 1'b0, 1'b0};
        vecs_a[5]  = '{32'h800000, 32'h800000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000001, 1'b1, 1'b0};
        vecs_a[6]  = '{32'h000000, 32'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000000, 1'b0, 1'b1};
        vecs_a[7]  = '{32'h123456, 32'h000001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h123457, 1'b0, 1'b0};
        vecs_a[8]  = '{32'h000FFF, 32'hFFF001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h000001, 1'b1, 1'b0};
        vecs_a[9]  = '{32'hFFFFFF, 32'h000002, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000002, 1'b1, 1'b0};
        vecs_a[10] = '{32'h123456, 32'h000001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h123457, 1'b0, 1'b0};
        vecs_a[11] = '{32'hFFFFFF, 32'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000000, 1'b1, 1'b1};

        vecs_b[0]  = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0};
        vecs_b[1]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1};
        vecs_b[2]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs_b[3]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs_b[4]  = '{32'h12345678, 32'hFEDCBA98, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0};

        bus_a.in_valid = 1'b0;  bus_a.in1 = '0;  bus_a.in2 = '0;  bus_a.cin = 1'b0;
        bus_a.sticky = 1'b0;  bus_a.eff_op = 1'b0;  bus_a.pos_zero_en = 1'b0;
        bus_a.tag_in = '0;  bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0;  bus_b.in1 = '0;  bus_b.in2 = '0;  bus_b.cin = 1'b0;
        bus_b.sticky = 1'b0;  bus_b.eff_op = 1'b0;  bus_b.pos_zero_en = 1'b0;
        bus_b.tag_in = '0;  bus_b.out_ready = 1'b1;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_reset_state(1'b0, "rst_a");
        check_reset_state(1'b1, "rst_b");
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_vec(1'b0, vecs_a[i], 8'(8'h10 + i), 2, $sformatf("vec_a%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            run_vec(1'b1, vecs_b[i], 8'(8'h20 + i), 1, $sformatf("vec_b%0d", i));
        end

        // Backpressure: four beats, output stalled for cycles 2..4, then released.
        nxt = 1;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (nxt <= 4) begin
                bp = '{32'(nxt * 32'h111), 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
                drive(1'b0, bp, 8'(nxt));
            end else begin
                idle(1'b0);
            end
            bus_a.out_ready = (cyc >= 5);
            #1;
            if (bus_a.out_valid && !bus_a.out_ready) begin
                check_eq("bp_hold_tag", get_tag(1'b0), 64'd1);
                check_eq("bp_hold_sum", get_sum(1'b0), 64'h121);
                check_eq("bp_hold_in_ready", get_ir(1'b0), 64'd0);
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                check_eq("bp_order_tag", get_tag(1'b0), 64'(got + 1));
                check_eq("bp_order_sum", get_sum(1'b0), 64'((got + 1) * 'h111 + 'h10));
                got++;
            end
            if (bus_a.in_valid && bus_a.in_ready) nxt++;
            @(posedge clk); #1;
        end
        idle(1'b0);
        check_eq("bp_count", 64'(got), 64'd4);
        check_eq("bp_drained", get_ov(1'b0), 64'd0);
        bus_a.out_ready = 1'b1;

        // Reset with two beats in flight in the 2-stage instance.
        drive(1'b0, vecs_a[0], 8'hA1);
        @(posedge clk); #1;
        drive(1'b0, vecs_a[1], 8'hA2);
        @(posedge clk); #1;
        idle(1'b0);
        check_eq("mid_a_pre_out_valid", get_ov(1'b0), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_a_out_valid", get_ov(1'b0), 64'd0);
        check_eq("mid_a_sum", get_sum(1'b0), 64'd0);
        check_eq("mid_a_tag", get_tag(1'b0), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_reset_state(1'b0, "mid_a_after");
        @(posedge clk); #1;
        check_eq("mid_a_no_ghost", get_ov(1'b0), 64'd0);
        run_vec(1'b0, vecs_a[7], 8'hA3, 2, "post_rst_a");

        // Reset with a stalled beat in the 1-stage instance.
        bus_b.out_ready = 1'b0;
        drive(1'b1, vecs_b[4], 8'hB1);
        @(posedge clk); #1;
        idle(1'b1);
        check_eq("mid_b_pre_out_valid", get_ov(1'b1), 64'd1);
        check_eq("mid_b_pre_in_ready", get_ir(1'b1), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_b_out_valid", get_ov(1'b1), 64'd0);
        check_eq("mid_b_sum", get_sum(1'b1), 64'd0);
        check_eq("mid_b_tag", get_tag(1'b1), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_b.out_ready = 1'b1;
        #1;
        check_reset_state(1'b1, "mid_b_after");
        @(posedge clk); #1;
        run_vec(1'b1, vecs_b[1], 8'hB2, 1, "post_rst_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eac_cla_adder_pipe.md
Name: eac_cla_adder_pipe

Overview:
- Pipelined, parametrised end-around-carry (EAC) carry-select/look-ahead adder for the BF16 FMA mantissa datapath.
- Generalises the combinational EAC adder in three ways:
  - configurable width, group size and pipeline depth (1 or 2 stages);
  - valid/ready flow control with an opaque tag passthrough;
  - a positive-zero normalisation mode and a zero flag.
- Sits between the alignment shifter and the leading-zero anticipator/normaliser.

Parameters:
- ADDER_WIDTH, 24, operand/sum width W.
- CLA_GRP_WIDTH, 12, CLA group width G. W mod G must be 0; N_CLA_GROUPS = W/G ≥ 2.
- PIPE_STAGES, 2, latency in cycles. Legal values are 1 or 2; any other value is an elaboration error.
- TAG_WIDTH, 8, width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in1  in  W  operand A.
- in2  in  W  operand B (already ones'-complemented upstream for subtract).
- cin  in  1  carry-in; used only in non-EAC mode.
- sticky  in  1  alignment sticky bit; 1 disables the end-around wrap.
- eff_op  in  1  effective operation; 1 = subtract (EAC-capable), 0 = add.
- pos_zero_en  in  1  1 = map all-ones EAC result (-0) to +0.
- tag_in  in  TAG_WIDTH  sideband carried with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- sum  out  W  result.
- cout  out  1  carry out of the W-bit addition.
- zero  out  1  sum == 0.
- tag_out  out  TAG_WIDTH  tag of the output beat.

Behaviour:
- Mode definition: eac = eff_op & ~sticky. Let R = in1 + in2, a (W+1)-bit value; c = R[W].
- eac = 1: sum = R[W-1:0] + c (mod 2^W), cout = c.
  - If R[W-1:0] is all ones, c = 0 and pos_zero_en = 1: sum = 0, cout = 1.
  - Same all-ones case with pos_zero_en = 0: sum = all ones, cout = 0.
- eac = 0: {cout, sum} = in1 + in2 + cin.
- zero = (sum == 0), computed on the final sum.
- Structure:
  - Each group computes sum_basic, sum_plus_one and group generate/propagate.
  - Group carries come from a rotated look-ahead. The wrap into group 0 is enabled only when eac = 1; otherwise group 0 carry-in is cin.
  - Group 0 selects sum_plus_one when its carry-in is 1.
- PIPE_STAGES = 2:
  - Stage 1 registers group sums, group G/P, eac, cin, pos_zero_en and tag.
  - Stage 2 registers carry resolution, selection, cout and zero.
- PIPE_STAGES = 1: everything is computed combinationally, then registered once.
- Latency: exactly PIPE_STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Flow control:
  - Each stage holds a valid bit.
  - A stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = ~v1 | (stage 1 advances); stage 1 advances when stage 2 is empty or out_ready = 1.
  - in_ready has no combinational dependence on in_valid.
  - While out_valid = 1 and out_ready = 0, sum/cout/zero/tag_out hold stable.
  - Bubbles collapse: an empty stage always accepts from the stage behind it.
  - Simultaneous accept and drain in a full pipe moves all beats by one stage with no loss or duplication.
- Reset (async assert, sync deassert externally):
  - All valid bits clear; out_valid = 0, in_ready = 1 on the first cycle after deassert.
  - sum = 0, cout = 0, zero = 0, tag_out = 0.
  - Reset mid-operation drops in-flight beats.
- Order is strictly preserved; tag_out equals the tag_in of the same beat.

Decomposition:
- Shared package: ADDER_WIDTH, CLA_GRP_WIDTH and derived N_CLA_GROUPS defaults, plus the W mod G legality check function.
- Sub-module eac_cla_group_pg: G-bit group producing sum_basic, sum_plus_one, GG and GP.
- The top level instantiates N_CLA_GROUPS copies and owns the rotation look-ahead, the pipeline registers and the handshake.

Test Plan:
- Plain add: eff_op = 0, in1 = 0x00FFFF, in2 = 0x000001, cin = 0, out_ready = 1 → after 2 cycles: sum = 0x010000, cout = 0, zero = 0.
- EAC wrap: eff_op = 1, sticky = 0, in1 = 0xFFFFFF, in2 = 0x000002 → sum = 0x000002, cout = 1.
- Sticky blocks wrap: same operands, sticky = 1, cin = 0 → sum = 0x000001, cout = 1.
- Positive zero: eff_op = 1, sticky = 0, in1 = 0xAAAAAA, in2 = 0x555555.
  - pos_zero_en = 1 → sum = 0x000000, cout = 1, zero = 1.
  - pos_zero_en = 0 → sum = 0xFFFFFF, cout = 0, zero = 0.
- Backpressure: 4 back-to-back beats with tags 1..4, out_ready = 0 for 3 cycles.
  - in_ready drops after 2 beats are held.
  - Outputs stay stable while stalled.
  - On release, tags emerge in order 1, 2, 3, 4 with correct sums and no duplicates.
- Reset mid-flight: rst_n low for 1 cycle with 2 beats in the pipe → out_valid = 0 immediately; sum = 0, tag_out = 0; a fresh beat afterwards returns after exactly PIPE_STAGES cycles (repeat with PIPE_STAGES = 1, W = 32, G = 8).
